// File: rtl/snake_datapath_if.sv
// snake_datapath_if
//   Bundles the controller strobes, direction request, VGA pixel port and
//   status signals exchanged between the snake controller and its datapath.
//   master : controller side (drives strobes, reads pixel/status outputs)
//   slave  : datapath side
//   Signals:
//     ld_head .. food_en      controller strobes, one-hot
//     cnt_status[1:0]         pixel offset inside a 2x2 cell (bit0 +x, bit1 +y)
//     colour_in[2:0]          colour for draw_q pixels
//     dir_in[1:0], dir_valid  direction request (00 up, 01 right, 10 down, 11 left)
//     x_out, y_out, colour_out, plot   registered VGA write
//     length[10:0]            current snake length
//     ate, game_over          eat pulse, sticky self-collision flag
interface snake_datapath_if;
    logic        ld_head;
    logic        ld_q_def;
    logic        inc_address;
    logic        rst_address;
    logic        draw_q;
    logic        update_head;
    logic        ld_head_into_prev;
    logic        ld_q_into_curr;
    logic        ld_prev_into_q;
    logic        ld_curr_into_prev;
    logic        draw_curr;
    logic        food_en;
    logic [1:0]  cnt_status;
    logic [2:0]  colour_in;
    logic [1:0]  dir_in;
    logic        dir_valid;
    logic [7:0]  x_out;
    logic [6:0]  y_out;
    logic [2:0]  colour_out;
    logic        plot;
    logic [10:0] length;
    logic        ate;
    logic        game_over;

    modport master (
        output ld_head, ld_q_def, inc_address, rst_address, draw_q, update_head,
               ld_head_into_prev, ld_q_into_curr, ld_prev_into_q, ld_curr_into_prev,
               draw_curr, food_en, cnt_status, colour_in, dir_in, dir_valid,
        input  x_out, y_out, colour_out, plot, length, ate, game_over
    );

    modport slave (
        input  ld_head, ld_q_def, inc_address, rst_address, draw_q, update_head,
               ld_head_into_prev, ld_q_into_curr, ld_prev_into_q, ld_curr_into_prev,
               draw_curr, food_en, cnt_status, colour_in, dir_in, dir_valid,
        output x_out, y_out, colour_out, plot, length, ate, game_over
    );
endinterface

// File: rtl/snake_datapath.sv
// snake_datapath
//   Body RAM, head/prev/curr/q registers, direction and food state for the
//   snake game. Executes the movement controller's strobes and produces
//   registered per-pixel VGA writes for 2x2 cells.
//   Ports:
//     clk   system clock
//     rst   synchronous reset, active-low
//     bus   snake_datapath_if.slave (strobes in, pixel/status out)
module snake_datapath #(
    parameter int MAX_LEN  = 64,
    parameter int INIT_LEN = 4,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int X0       = 80,
    parameter int Y0       = 60,
    parameter int FOOD_X0  = 120,
    parameter int FOOD_Y0  = 30
) (
    input logic             clk,
    input logic             rst,
    snake_datapath_if.slave bus
);
    localparam int AW = $clog2(MAX_LEN);

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;
    localparam logic [1:0] DIR_LEFT  = 2'b11;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
    } cell_t;

    cell_t          mem [MAX_LEN];
    logic [AW-1:0]  address;
    cell_t          q, head, prev, curr, food;
    cell_t          next_head, def_cell, new_food;
    logic [1:0]     dir, pend_dir;
    logic [10:0]    length_r;
    logic [15:0]    lfsr;
    logic [1:0]     food_cnt;
    logic           eat_chk;
    logic           game_over_r;
    logic [7:0]     x_r;
    logic [6:0]     y_r;
    logic [2:0]     colour_r;
    logic           plot_r;
    logic           ate_w;
    logic [8:0]     fx_raw;
    logic [7:0]     fy_raw;

    // Initial body is laid out leftward from the start head, one cell per address.
    assign def_cell.x = 8'(X0) - 8'({address, 1'b0});
    assign def_cell.y = 7'(Y0);

    always_comb begin
        next_head = head;
        case (pend_dir)
            DIR_UP:    next_head.y = (head.y == 7'd0) ? 7'(SCREEN_H - 2) : head.y - 7'd2;
            DIR_RIGHT: next_head.x = (head.x >= 8'(SCREEN_W - 2)) ? 8'd0 : head.x + 8'd2;
            DIR_DOWN:  next_head.y = (head.y >= 7'(SCREEN_H - 2)) ? 7'd0 : head.y + 7'd2;
            default:   next_head.x = (head.x == 8'd0) ? 8'(SCREEN_W - 2) : head.x - 8'd2;
        endcase
    end

    // Food candidate from the LFSR: even coordinates folded once into the screen.
    assign fx_raw = {1'b0, lfsr[6:0], 1'b0};
    assign fy_raw = {1'b0, lfsr[13:8], 1'b0};
    assign new_food.x = (fx_raw >= 9'(SCREEN_W)) ? 8'(fx_raw - 9'(SCREEN_W)) : fx_raw[7:0];
    assign new_food.y = (fy_raw >= 8'(SCREEN_H)) ? 7'(fy_raw - 8'(SCREEN_H)) : fy_raw[6:0];

    // eat_chk marks the cycle after update_head, when head holds the new position.
    assign ate_w = eat_chk && (head == food);

    // Body RAM: no reset, contents undefined until written.
    always_ff @(posedge clk) begin
        if (bus.ld_q_def) begin
            mem[address] <= def_cell;
        end else if (bus.ld_prev_into_q) begin
            mem[address] <= prev;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            address     <= '0;
            q           <= '0;
            head        <= '{x: 8'(X0), y: 7'(Y0)};
            prev        <= '0;
            curr        <= '0;
            dir         <= DIR_RIGHT;
            pend_dir    <= DIR_RIGHT;
            length_r    <= 11'(INIT_LEN);
            food        <= '{x: 8'(FOOD_X0), y: 7'(FOOD_Y0)};
            lfsr        <= 16'hACE1;
            food_cnt    <= 2'd0;
            eat_chk     <= 1'b0;
            game_over_r <= 1'b0;
            x_r         <= 8'd0;
            y_r         <= 7'd0;
            colour_r    <= 3'd0;
            plot_r      <= 1'b0;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            // Read-before-write: same-cycle write to address returns old data.
            q    <= mem[address];

            if (bus.rst_address) begin
                address <= '0;
            end else if (bus.inc_address) begin
                address <= address + 1'b1;
            end

            if (bus.ld_head) begin
                head <= '{x: 8'(X0), y: 7'(Y0)};
                dir  <= DIR_RIGHT;
            end else if (bus.update_head) begin
                head <= next_head;
                dir  <= pend_dir;
            end

            // Reversal is judged against the committed direction.
            if (bus.dir_valid && (bus.dir_in != (dir ^ 2'b10))) begin
                pend_dir <= bus.dir_in;
            end

            if (bus.ld_head_into_prev) begin
                prev <= head;
            end else if (bus.ld_curr_into_prev) begin
                prev <= curr;
            end

            if (bus.ld_q_into_curr) begin
                curr <= q;
                if ((address != '0) && (q == head)) begin
                    game_over_r <= 1'b1;
                end
            end

            eat_chk <= bus.update_head;

            if (ate_w) begin
                if (length_r < 11'(MAX_LEN)) begin
                    length_r <= length_r + 11'd1;
                end
                food <= new_food;
            end

            food_cnt <= bus.food_en ? food_cnt + 2'd1 : 2'd0;

            if (bus.draw_q) begin
                x_r      <= q.x + 8'(bus.cnt_status[0]);
                y_r      <= q.y + 7'(bus.cnt_status[1]);
                colour_r <= bus.colour_in;
                plot_r   <= 1'b1;
            end else if (bus.draw_curr) begin
                x_r      <= curr.x + 8'(bus.cnt_status[0]);
                y_r      <= curr.y + 7'(bus.cnt_status[1]);
                colour_r <= 3'b000;
                plot_r   <= 1'b1;
            end else if (bus.food_en) begin
                x_r      <= food.x + 8'(food_cnt[0]);
                y_r      <= food.y + 7'(food_cnt[1]);
                colour_r <= 3'b010;
                plot_r   <= 1'b1;
            end else begin
                plot_r   <= 1'b0;
            end
        end
    end

    assign bus.x_out      = x_r;
    assign bus.y_out      = y_r;
    assign bus.colour_out = colour_r;
    assign bus.plot       = plot_r;
    assign bus.length     = length_r;
    assign bus.ate        = ate_w;
    assign bus.game_over  = game_over_r;
endmodule

// File: tb/tb_snake_datapath.sv
// tb_snake_datapath
//   Self-checking bench for snake_datapath. Pixel writes are scoreboarded:
//   the expected pixel is queued when a draw strobe is driven and popped when
//   plot is seen. Status outputs are checked directly against a small model.
module tb_snake_datapath;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    snake_datapath_if bus();

    snake_datapath dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    localparam int S_LD_HEAD   = 0;
    localparam int S_LD_Q_DEF  = 1;
    localparam int S_INC       = 2;
    localparam int S_RST_ADDR  = 3;
    localparam int S_UPD       = 4;
    localparam int S_HEAD_PREV = 5;
    localparam int S_Q_CURR    = 6;
    localparam int S_PREV_Q    = 7;
    localparam int S_CURR_PREV = 8;

    pix_t        exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          ate_cnt = 0;
    bit          probe_on = 1'b0;
    int          pn = 0;
    logic [7:0]  px [4];
    logic [6:0]  py [4];
    logic [2:0]  pc [4];
    logic [7:0]  mx [4];
    logic [6:0]  my [4];
    logic [7:0]  hx;
    logic [6:0]  hy;

    task automatic check(input string tag, input int obs, input int want);
        n_cmp++;
        if (obs != want) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, want);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b1 && bus.ate === 1'b1) ate_cnt++;
        if (rst === 1'b1 && bus.plot === 1'b1) begin
            if (probe_on) begin
                if (pn < 4) begin
                    px[pn] = bus.x_out;
                    py[pn] = bus.y_out;
                    pc[pn] = bus.colour_out;
                end
                pn++;
            end else if (exp_q.size() == 0) begin
                check("sb_unexpected_plot", int'(bus.plot), 0);
            end else begin
                pix_t e;
                e = exp_q.pop_front();
                check("pix_x", int'(bus.x_out), int'(e.x));
                check("pix_y", int'(bus.y_out), int'(e.y));
                check("pix_colour", int'(bus.colour_out), int'(e.c));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_strobe(input int s, input logic v);
        case (s)
            S_LD_HEAD:   bus.ld_head = v;
            S_LD_Q_DEF:  bus.ld_q_def = v;
            S_INC:       bus.inc_address = v;
            S_RST_ADDR:  bus.rst_address = v;
            S_UPD:       bus.update_head = v;
            S_HEAD_PREV: bus.ld_head_into_prev = v;
            S_Q_CURR:    bus.ld_q_into_curr = v;
            S_PREV_Q:    bus.ld_prev_into_q = v;
            S_CURR_PREV: bus.ld_curr_into_prev = v;
            default:     ;
        endcase
    endtask

    task automatic strobe(input int s, input int n = 1);
        for (int i = 0; i < n; i++) begin
            set_strobe(s, 1'b1);
            tick();
        end
        set_strobe(s, 1'b0);
    endtask

    task automatic draw_cell(input logic [7:0] cx, input logic [6:0] cy,
                             input int ncnt, input bit erase);
        pix_t p;
        for (int k = 0; k < ncnt; k++) begin
            bus.cnt_status = 2'(k);
            bus.colour_in  = 3'b111;
            if (erase) bus.draw_curr = 1'b1;
            else       bus.draw_q    = 1'b1;
            p.x = cx + 8'(k & 1);
            p.y = cy + 7'((k >> 1) & 1);
            p.c = erase ? 3'b000 : 3'b111;
            exp_q.push_back(p);
            tick();
        end
        bus.draw_q     = 1'b0;
        bus.draw_curr  = 1'b0;
        bus.cnt_status = 2'd0;
    endtask

    // Head motion model: 2 px steps with screen wrap.
    task automatic model_move(input logic [1:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            case (d)
                2'b00: hy = (hy == 0) ? 7'd118 : hy - 7'd2;
                2'b01: hx = (hx >= 158) ? 8'd0 : hx + 8'd2;
                2'b10: hy = (hy >= 118) ? 7'd0 : hy + 7'd2;
                default: hx = (hx == 0) ? 8'd158 : hx - 8'd2;
            endcase
        end
    endtask

    task automatic request_dir(input logic [1:0] d);
        bus.dir_in    = d;
        bus.dir_valid = 1'b1;
        tick();
        bus.dir_valid = 1'b0;
    endtask

    // Shift the 4-cell body one step: head enters cell 0, old tail ends in curr.
    task automatic shift4();
        logic [7:0] pvx, cvx;
        logic [6:0] pvy, cvy;
        strobe(S_RST_ADDR);
        strobe(S_HEAD_PREV);
        pvx = hx;
        pvy = hy;
        for (int i = 0; i < 4; i++) begin
            tick();
            strobe(S_Q_CURR);
            strobe(S_PREV_Q);
            strobe(S_CURR_PREV);
            strobe(S_INC);
            cvx = mx[i]; cvy = my[i];
            mx[i] = pvx; my[i] = pvy;
            pvx = cvx;   pvy = cvy;
        end
        draw_cell(pvx, pvy, 4, 1'b1);
    endtask

    task automatic readback(input int ncnt);
        strobe(S_RST_ADDR);
        for (int i = 0; i < 4; i++) begin
            tick();
            draw_cell(mx[i], my[i], ncnt, 1'b0);
            strobe(S_INC);
        end
    endtask

    initial begin
        bus.ld_head = 0; bus.ld_q_def = 0; bus.inc_address = 0; bus.rst_address = 0;
        bus.draw_q = 0; bus.update_head = 0; bus.ld_head_into_prev = 0;
        bus.ld_q_into_curr = 0; bus.ld_prev_into_q = 0; bus.ld_curr_into_prev = 0;
        bus.draw_curr = 0; bus.food_en = 0; bus.cnt_status = 0; bus.colour_in = 0;
        bus.dir_in = 0; bus.dir_valid = 0;
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;

        check("rst_length", int'(bus.length), 4);
        check("rst_plot", int'(bus.plot), 0);
        check("rst_x_out", int'(bus.x_out), 0);
        check("rst_y_out", int'(bus.y_out), 0);
        check("rst_colour", int'(bus.colour_out), 0);
        check("rst_ate", int'(bus.ate), 0);
        check("rst_game_over", int'(bus.game_over), 0);

        // Initial body layout.
        strobe(S_LD_HEAD);
        hx = 8'd80; hy = 7'd60;
        for (int i = 0; i < 4; i++) begin
            strobe(S_LD_Q_DEF);
            strobe(S_INC);
            mx[i] = 8'(80 - 2 * i);
            my[i] = 7'd60;
        end
        check("init_length", int'(bus.length), 4);
        check("init_plot", int'(bus.plot), 0);
        readback(4);
        check("hold_x_out", int'(bus.x_out), 75);
        check("hold_y_out", int'(bus.y_out), 61);
        check("hold_plot", int'(bus.plot), 0);

        // Food drawing at reset position, twice to show food_cnt clears.
        for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < 4; k++) begin
                pix_t p;
                bus.food_en = 1'b1;
                p.x = 8'(120 + (k & 1));
                p.y = 7'(30 + ((k >> 1) & 1));
                p.c = 3'b010;
                exp_q.push_back(p);
                tick();
            end
            bus.food_en = 1'b0;
            tick();
        end

        // Right-edge wrap, then shift to expose head in mem[0].
        strobe(S_UPD, 40);
        model_move(2'b01, 40);
        shift4();
        readback(1);

        // Reversal request ignored; head keeps moving right.
        request_dir(2'b11);
        strobe(S_UPD);
        model_move(2'b01, 1);
        shift4();
        readback(1);
        check("shift_no_game_over", int'(bus.game_over), 0);
        check("pre_eat_ate_cnt", ate_cnt, 0);

        // Walk to the food at (120,30).
        request_dir(2'b00);
        strobe(S_UPD, 15);
        model_move(2'b00, 15);
        request_dir(2'b01);
        strobe(S_UPD, 58);
        model_move(2'b01, 58);
        check("pre_eat_ate", int'(bus.ate), 0);
        strobe(S_UPD);
        model_move(2'b01, 1);
        check("eat_ate_high", int'(bus.ate), 1);
        tick();
        check("eat_ate_low", int'(bus.ate), 0);
        check("eat_length", int'(bus.length), 5);
        check("eat_pulse_count", ate_cnt, 1);

        // New food position: in range, even, drawn in green.
        probe_on = 1'b1;
        bus.food_en = 1'b1;
        repeat (4) tick();
        bus.food_en = 1'b0;
        tick();
        probe_on = 1'b0;
        check("food_pixels", pn, 4);
        check("food_x_even", int'(px[0][0]), 0);
        check("food_y_even", int'(py[0][0]), 0);
        check("food_x_range", int'(px[0] < 8'd160), 1);
        check("food_y_range", int'(py[0] < 7'd120), 1);
        for (int k = 0; k < 4; k++) check("food_colour", int'(pc[k]), 2);

        // Read-during-write returns old data; address 0 never flags collision.
        strobe(S_RST_ADDR);
        strobe(S_HEAD_PREV);
        strobe(S_PREV_Q);
        draw_cell(mx[0], my[0], 1, 1'b0);
        mx[0] = hx; my[0] = hy;
        draw_cell(mx[0], my[0], 1, 1'b0);
        strobe(S_Q_CURR);
        check("addr0_no_game_over", int'(bus.game_over), 0);
        strobe(S_INC, 2);
        tick();
        strobe(S_Q_CURR);
        check("addr2_body_ok", int'(bus.game_over), 0);
        strobe(S_PREV_Q);
        tick();
        strobe(S_Q_CURR);
        check("collision_game_over", int'(bus.game_over), 1);
        repeat (3) tick();
        check("game_over_sticky", int'(bus.game_over), 1);

        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("rerst_game_over", int'(bus.game_over), 0);
        check("rerst_length", int'(bus.length), 4);

        repeat (2) tick();
        check("sb_drain", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/snake_datapath.md
Name: snake_datapath

Overview:
- Datapath driven by the snake movement controller FSM. It consumes that controller's one-hot strobes and returns `length`.
- Holds the snake body RAM, the head/prev/curr/q shift registers, the direction register and the food position.
- Emits per-pixel VGA writes for 2x2 cells, plus the eat and self-collision status used by the game top level.

Parameters:
- MAX_LEN, 64, body RAM depth in cells (power of two).
- INIT_LEN, 4, length after reset (>=2, <=MAX_LEN).
- SCREEN_W, 160, screen width in pixels (even).
- SCREEN_H, 120, screen height in pixels (even).
- X0, 80, initial head x (even). Y0, 60, initial head y (even).
- FOOD_X0, 120, food x after reset. FOOD_Y0, 30, food y after reset.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low
- ld_head, ld_q_def, inc_address, rst_address, draw_q, update_head, ld_head_into_prev, ld_q_into_curr, ld_prev_into_q, ld_curr_into_prev, draw_curr, food_en  in  1 each  controller strobes
- cnt_status  in  2  pixel offset within cell: bit0 -> +x, bit1 -> +y
- colour_in  in  3  colour used for draw_q pixels
- dir_in  in  2  requested direction: 00 up, 01 right, 10 down, 11 left
- dir_valid  in  1  dir_in qualifier
- x_out  out  8  VGA pixel x
- y_out  out  7  VGA pixel y
- colour_out  out  3  VGA pixel colour
- plot  out  1  VGA write enable
- length  out  11  current snake length, to controller
- ate  out  1  one-cycle pulse when the head lands on food
- game_over  out  1  sticky self-collision flag

Behaviour:
- Reset (rst==0 at posedge clk):
  - address=0, head=(X0,Y0), prev=curr=q=0, dir=right, pend_dir=right.
  - length=INIT_LEN, food=(FOOD_X0,FOOD_Y0), lfsr=16'hACE1, food_cnt=0.
  - x_out=0, y_out=0, colour_out=0, plot=0, ate=0, game_over=0.
  - RAM contents undefined.
- Cell word: {x[7:0], y[6:0]}.
- RAM reads are synchronous: q <= mem[address] every cycle, so q is valid one cycle after address changes. A write and a read of the same address in one cycle returns the old data.
- address:
  - rst_address clears it to 0; rst_address wins over inc_address.
  - inc_address adds 1, wrapping MAX_LEN-1 -> 0.
- Strobes are one-hot. If several are asserted in one cycle, the register updates below are each applied independently; the output priority is draw_q > draw_curr > food_en.
- ld_head: head <= (X0,Y0); dir <= right.
- ld_q_def: mem[address] <= (X0 - 2*address mod 256, Y0). This lays the initial body out leftward.
- update_head:
  - dir <= pend_dir, then head moves 2 px in that direction.
  - x: right at x >= SCREEN_W-2 wraps to 0; left at x==0 wraps to SCREEN_W-2.
  - y: down at y >= SCREEN_H-2 wraps to 0; up at y==0 wraps to SCREEN_H-2.
- ld_head_into_prev: prev <= head.
- ld_q_into_curr: curr <= q. If address != 0 and q == head, game_over <= 1 (sticky until reset).
- ld_prev_into_q: mem[address] <= prev.
- ld_curr_into_prev: prev <= curr.
- Direction: on dir_valid, pend_dir <= dir_in, unless dir_in == dir ^ 2'b10 (reversal), which is ignored. The last valid request before update_head wins.
- Eating:
  - Checked in the cycle after update_head, against the new head: if head == food, ate=1 for one cycle.
  - On that pulse, length increments, saturating at MAX_LEN.
  - On that pulse, food relocates from the lfsr: fx={lfsr[6:0],0}, minus SCREEN_W if >= SCREEN_W; fy={lfsr[13:8],0}, minus SCREEN_H if >= SCREEN_H.
- lfsr: 16-bit Fibonacci LFSR, taps 16,14,13,11, advances every cycle, never zero.
- Pixel output is registered, with 1-cycle latency from strobe to plot:
  - draw_q: (q.x + cnt_status[0], q.y + cnt_status[1]), colour_in, plot=1.
  - draw_curr: (curr.x + cnt_status[0], curr.y + cnt_status[1]), colour 000 (erases the tail), plot=1.
  - food_en: food + {food_cnt[1], food_cnt[0]} offset, colour 010, plot=1.
    - food_cnt increments while food_en is high and clears when it is low.
  - None of the above: plot=0; x_out and y_out hold their values.

Test Plan:
- Reset, then ld_head, then ld_q_def with address stepped 0..3 -> mem = (80,60),(78,60),(76,60),(74,60); length=4; plot=0.
- rst_address, then draw_q with cnt_status 0..3 and colour_in=111 at address 1 -> pixels (78,60),(79,60),(78,61),(79,61), each one cycle after its strobe.
- dir=right, head=(158,60), update_head -> head=(0,60). Then dir_valid with dir_in=11 (reversal) -> ignored; next update_head -> head=(2,60).
- Food placed at the new head position, update_head -> ate high for exactly one cycle, length 4->5, food moves to an lfsr-derived cell with x<160, y<120, both even.
- Full shift sequence (head_into_prev, then q_into_curr / prev_into_q / curr_into_prev per cell) -> mem[0]=new head, mem[i]=old mem[i-1]; curr=old tail; draw_curr erases the old tail in colour 000.
- Body cell equal to the new head during ld_q_into_curr at address 2 -> game_over=1, and it stays 1 until rst is held low for one clk.
